spi_master_ctrl: RTL and testbench

Single-clock SPI controller that drives the master end of the team's SPI-slave/RAM link: it serialises 10-bit command words onto MOSI under SS_n framing and, for read-data commands, deserialises the 8-bit reply from MISO. It sits between a host-side request port (CPU or test sequencer) and the SPI slave. The slave runs on the same clk, so no SCLK is generated.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_shreg.sv | 39 +++
 rtl/spi_master_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: FSM states, opcodes,
// default widths and the counter sizing helper.
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int RD_WAIT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_COMMIT,
        ST_WAIT,
        ST_RECV,
        ST_DESEL
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Width able to hold the largest reload value of any phase counter.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_shreg.sv
// Parallel-load, MSB-first shift register. Serial data enters at bit 0 and
// the word moves toward the MSB on every shift.
module spi_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = par_in;
        end else if (shift) begin
            data_d = {data_q[WIDTH-2:0], ser_in};
        end
    end

    // Register the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_out = data_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: frames a command word under SS_n, shifts it out on
// MOSI and, for read-data commands, collects the slave's reply from MISO.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] cmd,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int CNT_W = cnt_width(FRAME_W, DATA_W, RD_WAIT);
    localparam logic [CNT_W-1:0] LD_SHIFT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_RECV  = CNT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                ss_n_q, ss_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                accept;
    logic                tx_shift;
    logic                rx_shift;
    logic [FRAME_W-1:0]  tx_par;
    logic [DATA_W-1:0]   rx_par;
    logic                shreg_unused;

    // DESEL doubles as an acceptance point so that a held start produces
    // back-to-back frames with exactly one SS_n-high cycle between them.
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DESEL));
    assign tx_shift = (state_d == ST_SHIFT);
    assign rx_shift = (state_q == ST_RECV);

    // The TX word is only observed at its MSB, and the RX MSB is replaced by
    // the look-ahead word captured on the final RECV edge.
    assign shreg_unused = ^{tx_par[FRAME_W-2:0], rx_par[DATA_W-1]};

    spi_shreg #(.WIDTH(FRAME_W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .shift   (tx_shift),
        .par_in  (cmd),
        .ser_in  (1'b0),
        .par_out (tx_par)
    );

    spi_shreg #(.WIDTH(DATA_W)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (1'b0),
        .shift   (rx_shift),
        .par_in  ('0),
        .ser_in  (MISO),
        .par_out (rx_par)
    );

    // Next-state, phase counter and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE, ST_DESEL: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_SEL;
                    op_d    = cmd[FRAME_W-1 -: 2];
                end
            end
            ST_SEL: begin
                state_d = ST_SHIFT;
                cnt_d   = LD_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == '0) state_d = ST_COMMIT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_COMMIT: begin
                if (op_q == OP_RD_DATA) begin
                    state_d = ST_WAIT;
                    cnt_d   = LD_WAIT;
                end else begin
                    state_d = ST_DESEL;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECV;
                    cnt_d   = LD_RECV;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RECV: begin
                if (cnt_q == '0) state_d = ST_DESEL;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        ss_n_d = !((state_d == ST_SEL)    || (state_d == ST_SHIFT) ||
                   (state_d == ST_COMMIT) || (state_d == ST_WAIT)  ||
                   (state_d == ST_RECV));
        mosi_d = 1'b0;
        if (state_d == ST_SEL)        mosi_d = cmd[FRAME_W-1];
        else if (state_d == ST_SHIFT) mosi_d = tx_par[FRAME_W-1];
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DESEL);
        rd_valid_d = (state_d == ST_DESEL) && (op_q == OP_RD_DATA);
        rd_data_d  = rd_data_q;
        if ((state_q == ST_RECV) && (state_d == ST_DESEL)) begin
            rd_data_d = {rx_par[DATA_W-2:0], MISO};
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_WR_ADDR;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: table of frames plus hand-written
// reset, back-to-back and async-reset sequences.
module tb_spi_master_ctrl;

    localparam int NCAP = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] cmd;
    logic       busy, done, rd_valid, SS_n, MOSI, MISO;
    logic [7:0] rd_data;

    spi_master_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd      (cmd),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       ss_a   [NCAP];
    logic       mosi_a [NCAP];
    logic       done_a [NCAP];
    logic       rv_a   [NCAP];
    logic       busy_a [NCAP];
    logic [7:0] rd_a   [NCAP];

    typedef struct {
        logic [9:0] cmd;
        logic [7:0] miso;
        bit         glitch;
        int         exp_low;
        logic       exp_rv;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start with c and step through the accepting edge (k=0 afterwards).
    task automatic begin_frame(input logic [9:0] c);
        start = 1'b1;
        cmd   = c;
        tick();
    endtask

    // Record outputs for NCAP cycles after acceptance. The slave model drives
    // reply bit 7 from k=15 (first RECV cycle) down to bit 0 at k=22. start is
    // driven high with scmd for k in [s_k, s_k+s_len).
    task automatic capture(input logic [7:0] mb, input int s_k, input int s_len,
                           input logic [9:0] scmd);
        for (int k = 0; k < NCAP; k++) begin
            ss_a[k]   = SS_n;
            mosi_a[k] = MOSI;
            done_a[k] = done;
            rv_a[k]   = rd_valid;
            busy_a[k] = busy;
            rd_a[k]   = rd_data;
            if (k >= 15 && k <= 22) MISO = mb[22-k];
            else                    MISO = 1'b0;
            if (k >= s_k && k < s_k + s_len) begin
                start = 1'b1;
                cmd   = scmd;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        MISO  = 1'b0;
        start = 1'b0;
    endtask

    function automatic logic [10:0] mosi_seq(input int k0);
        logic [10:0] s;
        for (int i = 0; i < 11; i++) s[10-i] = mosi_a[k0+i];
        return s;
    endfunction

    function automatic int count_low(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) if (ss_a[i] === 1'b0) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int i = 0; i < NCAP; i++) if (done_a[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_rv();
        int n = 0;
        for (int i = 0; i < NCAP; i++) if (rv_a[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_high();
        for (int i = 0; i < NCAP; i++) if (ss_a[i] === 1'b1) return i;
        return -1;
    endfunction

    initial begin
        int pulses;
        logic [9:0] c;

        vecs[0] = '{cmd: 10'h0A5, miso: 8'h00, glitch: 1'b0, exp_low: 12, exp_rv: 1'b0, exp_rd: 8'h00};
        vecs[1] = '{cmd: 10'h3FF, miso: 8'hC3, glitch: 1'b0, exp_low: 23, exp_rv: 1'b1, exp_rd: 8'hC3};
        vecs[2] = '{cmd: 10'h0A5, miso: 8'h00, glitch: 1'b1, exp_low: 12, exp_rv: 1'b0, exp_rd: 8'hC3};
        vecs[3] = '{cmd: 10'h1AB, miso: 8'h00, glitch: 1'b0, exp_low: 12, exp_rv: 1'b0, exp_rd: 8'hC3};
        vecs[4] = '{cmd: 10'h35A, miso: 8'hA5, glitch: 1'b0, exp_low: 23, exp_rv: 1'b1, exp_rd: 8'hA5};
        vecs[5] = '{cmd: 10'h2F0, miso: 8'h00, glitch: 1'b0, exp_low: 12, exp_rv: 1'b0, exp_rd: 8'hA5};

        rst_n = 1'b0;
        start = 1'b0;
        cmd   = '0;
        MISO  = 1'b0;
        #12;
        chk("reset_ss_n", SS_n, 1'b1);
        chk("reset_mosi", MOSI, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_rd_data", rd_data, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted during RECV of a read-data frame.
        begin_frame(10'h3FF);
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            MISO = (k >= 15) ? 1'b1 : 1'b0;
            tick();
        end
        chk("recv_busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("recv_reset_ss_n", SS_n, 1'b1);
        chk("recv_reset_mosi", MOSI, 1'b0);
        chk("recv_reset_busy", busy, 1'b0);
        chk("recv_reset_rd_data", rd_data, 8'h00);
        tick();
        rst_n = 1'b1;
        MISO  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1 || rd_valid === 1'b1) pulses++;
            tick();
        end
        chk("recv_reset_no_done", pulses, 0);
        chk("recv_reset_rd_data_after", rd_data, 8'h00);

        // Table of frames.
        for (int v = 0; v < 6; v++) begin
            c = vecs[v].cmd;
            begin_frame(c);
            if (vecs[v].glitch) capture(vecs[v].miso, 4, 1, 10'h3FF);
            else                capture(vecs[v].miso, -1, 0, 10'h000);
            chk($sformatf("v%0d_mosi", v), mosi_seq(0), {c[9], c});
            chk($sformatf("v%0d_busy_first", v), busy_a[0], 1'b1);
            chk($sformatf("v%0d_ss_low", v), count_low(0, NCAP-1), vecs[v].exp_low);
            chk($sformatf("v%0d_ss_rise", v), first_high(), vecs[v].exp_low);
            chk($sformatf("v%0d_done_at", v), done_a[vecs[v].exp_low], 1'b1);
            chk($sformatf("v%0d_done_count", v), count_done(), 1);
            chk($sformatf("v%0d_rv_at_done", v), rv_a[vecs[v].exp_low], vecs[v].exp_rv);
            chk($sformatf("v%0d_rv_count", v), count_rv(), {31'd0, vecs[v].exp_rv});
            chk($sformatf("v%0d_rd_data", v), rd_a[NCAP-1], vecs[v].exp_rd);
            chk($sformatf("v%0d_busy_end", v), busy_a[NCAP-1], 1'b0);
        end

        // Back-to-back frames with start held high.
        begin_frame(10'h012);
        capture(8'h00, 0, 13, 10'h1AB);
        chk("b2b_mosi_a", mosi_seq(0), {1'b0, 10'h012});
        chk("b2b_ss_low_a", count_low(0, 11), 12);
        chk("b2b_ss_gap", ss_a[12], 1'b1);
        chk("b2b_ss_low_b", count_low(13, 24), 12);
        chk("b2b_ss_end", ss_a[25], 1'b1);
        chk("b2b_done_a", done_a[12], 1'b1);
        chk("b2b_done_b", done_a[25], 1'b1);
        chk("b2b_done_count", count_done(), 2);
        chk("b2b_mosi_b", mosi_seq(13), {1'b0, 10'h1AB});

        // Asynchronous reset clears held read data between clock edges.
        chk("pre_async_rd_data", rd_data, 8'hA5);
        rst_n = 1'b0;
        #2;
        chk("async_rd_data", rd_data, 8'h00);
        chk("async_ss_n", SS_n, 1'b1);
        chk("async_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
